// File: rtl/eth_pkg.sv
// eth_pkg: constants, FSM state encoding and the output word type shared by
// the Ethernet receive deframer and the transmit framer.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD           = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IPV4     = 16'h0800;
  localparam int          ETH_HDR_BYTES     = 14;   // dst(6) + src(6) + type(2)

  typedef enum logic [2:0] {
    ST_HUNT, ST_PRE, ST_DST, ST_SRC, ST_TYPE, ST_PAY, ST_DROP
  } eth_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        err;
  } eth_word_t;

  // MSB-first contiguous byte enables for n packed bytes (0..4).
  function automatic logic [3:0] keep_mask(input logic [2:0] n);
    case (n)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1100;
      3'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/eth_rx_unpack.sv
// eth_rx_unpack: 48-to-8 gearbox. Holds one MAC beat and presents it one byte
// per cycle, byte 0 ([47:40]) first.
//   mac_rx_*   : beat input; ready is high whenever the hold register is empty
//   byte_*     : byte presented to the parser, byte_final tags the frame's last byte
//   stall      : parser cannot consume the presented byte this cycle
module eth_rx_unpack (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] mac_rx_data,
  input  logic        mac_rx_valid,
  input  logic        mac_rx_last,
  input  logic [2:0]  mac_rx_bytes,
  output logic        mac_rx_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_final,
  input  logic        stall
);

  logic [47:0] hold;
  logic [2:0]  idx, top_idx;
  logic        full, hold_last, end_beat, take;

  assign mac_rx_ready = !full && !rst;
  assign end_beat     = (idx == top_idx);
  assign take         = full && !stall;
  assign byte_valid   = full;
  assign byte_data    = hold[47:40];
  assign byte_final   = hold_last && end_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      idx       <= '0;
      top_idx   <= '0;
      full      <= 1'b0;
      hold_last <= 1'b0;
    end else if (mac_rx_valid && mac_rx_ready) begin
      hold      <= mac_rx_data;
      idx       <= '0;
      full      <= 1'b1;
      hold_last <= mac_rx_last;
      // out-of-range byte counts on a last beat are treated as a full beat
      top_idx   <= (mac_rx_last && mac_rx_bytes inside {[3'd1:3'd6]}) ?
                   mac_rx_bytes - 3'd1 : 3'd5;
    end else if (take) begin
      hold <= hold << 8;
      if (end_beat) full <= 1'b0;
      else          idx  <= idx + 3'd1;
    end
  end

endmodule

// File: rtl/eth_rx_deframer.sv
// eth_rx_deframer: receive Ethernet deframer. Validates preamble/SFD, dst MAC
// and EtherType, captures src MAC, and packs IPv4 payload into 32-bit words.
//   mac_rx_*     : 48-bit beat stream from the MAC
//   tcp_ip_rx_*  : payload words (data/keep/last/err) with valid/ready
//   rx_src_mac   : source MAC of the current/last accepted frame
//   rx_drop      : one-cycle pulse per discarded frame
// Build option ETH_RX_STATS_EN adds saturating stat_good/stat_drop counters.
module eth_rx_deframer
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR_LOCAL    = 48'h000A35000001,
  parameter int          MAX_PAYLOAD_BYTES = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] mac_rx_data,
  input  logic        mac_rx_valid,
  input  logic        mac_rx_last,
  input  logic [2:0]  mac_rx_bytes,
  output logic        mac_rx_ready,
  output logic [31:0] tcp_ip_rx_data,
  output logic [3:0]  tcp_ip_rx_keep,
  output logic        tcp_ip_rx_last,
  output logic        tcp_ip_rx_err,
  output logic        tcp_ip_rx_valid,
  input  logic        tcp_ip_rx_ready,
  output logic [47:0] rx_src_mac,
  output logic        rx_drop
`ifdef ETH_RX_STATS_EN
  ,
  output logic [15:0] stat_good,
  output logic [15:0] stat_drop
`endif
);

  localparam logic [10:0] PAY_MAX   = 11'(MAX_PAYLOAD_BYTES);
  localparam logic [2:0]  TYPE_LAST = 3'(ETH_HDR_BYTES - 13);  // index of 2nd type byte

  eth_state_e  state, state_nxt;
  logic        b_valid, b_final, stall, take;
  logic [7:0]  b_data, type_hi;
  logic [2:0]  pre_cnt, pre_nxt, hdr_cnt, hdr_nxt, pk_n, pk_n_nxt;
  logic        dst_ok, dst_ok_nxt, dst_hit, sat;
  logic        drop_req, emit_req, pack_en, enter_pay;
  logic [47:0] dst_cmp, src_sh, src_mac;
  logic [10:0] pay_cnt;
  logic [31:0] pk_data, pk_data_nxt;
  eth_word_t   ow;
  logic        ovalid, drop;

  eth_rx_unpack u_unpack (
    .clk          (clk),
    .rst          (rst),
    .mac_rx_data  (mac_rx_data),
    .mac_rx_valid (mac_rx_valid),
    .mac_rx_last  (mac_rx_last),
    .mac_rx_bytes (mac_rx_bytes),
    .mac_rx_ready (mac_rx_ready),
    .byte_valid   (b_valid),
    .byte_data    (b_data),
    .byte_final   (b_final),
    .stall        (stall)
  );

  assign sat         = (pay_cnt == PAY_MAX);
  assign dst_hit     = (b_data == dst_cmp[47:40]);
  assign pk_data_nxt = pack_en ? (pk_data | ({b_data, 24'h0} >> (8 * pk_n))) : pk_data;
  assign pk_n_nxt    = pack_en ? pk_n + 3'd1 : pk_n;
  // Only a byte that would load the output register waits on a full one.
  assign stall       = ovalid && !tcp_ip_rx_ready && emit_req;
  assign take        = b_valid && !stall;

  always_comb begin
    state_nxt  = state;
    pre_nxt    = pre_cnt;
    hdr_nxt    = hdr_cnt;
    dst_ok_nxt = dst_ok;
    drop_req   = 1'b0;
    emit_req   = 1'b0;
    pack_en    = 1'b0;
    enter_pay  = 1'b0;
    case (state)
      ST_HUNT:
        if (b_final) drop_req = 1'b1;
        else if (b_data == ETH_PREAMBLE_BYTE) begin
          state_nxt = ST_PRE;
          pre_nxt   = 3'd1;
        end else state_nxt = ST_DROP;
      ST_PRE:
        if (b_final) begin
          drop_req  = 1'b1;
          state_nxt = ST_HUNT;
        end else if (b_data == ETH_PREAMBLE_BYTE && pre_cnt != 3'd7) pre_nxt = pre_cnt + 3'd1;
        else if (b_data == ETH_SFD) begin
          state_nxt  = ST_DST;
          hdr_nxt    = '0;
          dst_ok_nxt = 1'b1;
        end else state_nxt = ST_DROP;
      ST_DST:
        if (b_final) begin
          drop_req  = 1'b1;
          state_nxt = ST_HUNT;
        end else if (hdr_cnt == 3'd5) begin
          state_nxt = (dst_ok && dst_hit) ? ST_SRC : ST_DROP;
          hdr_nxt   = '0;
        end else begin
          hdr_nxt    = hdr_cnt + 3'd1;
          dst_ok_nxt = dst_ok && dst_hit;
        end
      ST_SRC:
        if (b_final) begin
          drop_req  = 1'b1;
          state_nxt = ST_HUNT;
        end else if (hdr_cnt == 3'd5) begin
          state_nxt = ST_TYPE;
          hdr_nxt   = '0;
        end else hdr_nxt = hdr_cnt + 3'd1;
      ST_TYPE:
        if (b_final) begin
          drop_req  = 1'b1;
          state_nxt = ST_HUNT;
        end else if (hdr_cnt != TYPE_LAST) hdr_nxt = hdr_cnt + 3'd1;
        else begin
          hdr_nxt = '0;
          if ({type_hi, b_data} == ETH_TYPE_IPV4) begin
            state_nxt = ST_PAY;
            enter_pay = 1'b1;
          end else state_nxt = ST_DROP;
        end
      ST_PAY: begin
        // past the limit bytes are discarded; the frame-final byte still
        // flushes whatever is packed (possibly nothing) with err set
        pack_en  = !sat;
        emit_req = b_final || (!sat && pk_n == 3'd3);
        if (b_final) state_nxt = ST_HUNT;
      end
      ST_DROP:
        if (b_final) begin
          drop_req  = 1'b1;
          state_nxt = ST_HUNT;
        end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HUNT;
    else if (take) state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      hdr_cnt <= '0;
      dst_ok  <= 1'b0;
      dst_cmp <= '0;
      src_sh  <= '0;
      src_mac <= '0;
      type_hi <= '0;
      pay_cnt <= '0;
      pk_data <= '0;
      pk_n    <= '0;
    end else if (take) begin
      pre_cnt <= pre_nxt;
      hdr_cnt <= hdr_nxt;
      dst_ok  <= dst_ok_nxt;
      dst_cmp <= (state == ST_DST) ? dst_cmp << 8 : MAC_ADDR_LOCAL;
      if (state == ST_SRC)  src_sh  <= {src_sh[39:0], b_data};
      if (state == ST_TYPE) type_hi <= b_data;
      if (enter_pay) begin
        src_mac <= src_sh;
        pay_cnt <= '0;
        pk_data <= '0;
        pk_n    <= '0;
      end else if (state == ST_PAY) begin
        if (pack_en) pay_cnt <= pay_cnt + 11'd1;
        pk_data <= emit_req ? '0 : pk_data_nxt;
        pk_n    <= emit_req ? '0 : pk_n_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovalid <= 1'b0;
      ow     <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= take && drop_req;
      if (take && emit_req) begin
        ovalid <= 1'b1;
        ow     <= '{data: pk_data_nxt, keep: keep_mask(pk_n_nxt), last: b_final, err: sat};
      end else if (ovalid && tcp_ip_rx_ready) ovalid <= 1'b0;
    end
  end

  assign tcp_ip_rx_valid = ovalid;
  assign tcp_ip_rx_data  = ow.data;
  assign tcp_ip_rx_keep  = ow.keep;
  assign tcp_ip_rx_last  = ow.last;
  assign tcp_ip_rx_err   = ow.err;
  assign rx_src_mac      = src_mac;
  assign rx_drop         = drop;

`ifdef ETH_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good <= '0;
      stat_drop <= '0;
    end else begin
      if (ovalid && tcp_ip_rx_ready && ow.last && stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
      if (drop && stat_drop != 16'hFFFF) stat_drop <= stat_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_deframer.sv
module tb_eth_rx_deframer;
  import eth_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        err;
  } exp_t;

  localparam logic [47:0] MY_MAC = 48'h000A35000001;

  logic        clk = 1'b0, rst = 1'b1;
  logic [47:0] mac_rx_data = '0;
  logic        mac_rx_valid = 1'b0, mac_rx_last = 1'b0;
  logic [2:0]  mac_rx_bytes = 3'd6;
  logic        mac_rx_ready, tcp_rdy = 1'b1;
  logic [31:0] d_data;
  logic [3:0]  d_keep;
  logic        d_last, d_err, d_valid, d_drop;
  logic [47:0] d_src;
  // second instance with an 8-byte payload limit; it sees exactly the beats
  // accepted by the main instance and never back-pressures
  logic        v8_in, rdy8;
  logic [31:0] e_data;
  logic [3:0]  e_keep;
  logic        e_last, e_err, e_valid, e_drop;
  logic [47:0] e_src;
`ifdef ETH_RX_STATS_EN
  logic [15:0] sg0, sd0, sg1, sd1;
`endif

  int n_chk = 0, n_err = 0, hs_cnt = 0, drop_cnt = 0;
  exp_t exp_q[$], exp8_q[$];
  logic [37:0] prev_w;
  bit held = 0;

  always #5 clk = ~clk;
  assign v8_in = mac_rx_valid && mac_rx_ready;

  eth_rx_deframer #(.MAC_ADDR_LOCAL(MY_MAC), .MAX_PAYLOAD_BYTES(1500)) dut (
    .clk(clk), .rst(rst), .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid),
    .mac_rx_last(mac_rx_last), .mac_rx_bytes(mac_rx_bytes), .mac_rx_ready(mac_rx_ready),
    .tcp_ip_rx_data(d_data), .tcp_ip_rx_keep(d_keep), .tcp_ip_rx_last(d_last),
    .tcp_ip_rx_err(d_err), .tcp_ip_rx_valid(d_valid), .tcp_ip_rx_ready(tcp_rdy),
    .rx_src_mac(d_src), .rx_drop(d_drop)
`ifdef ETH_RX_STATS_EN
    , .stat_good(sg0), .stat_drop(sd0)
`endif
  );

  eth_rx_deframer #(.MAC_ADDR_LOCAL(MY_MAC), .MAX_PAYLOAD_BYTES(8)) dut8 (
    .clk(clk), .rst(rst), .mac_rx_data(mac_rx_data), .mac_rx_valid(v8_in),
    .mac_rx_last(mac_rx_last), .mac_rx_bytes(mac_rx_bytes), .mac_rx_ready(rdy8),
    .tcp_ip_rx_data(e_data), .tcp_ip_rx_keep(e_keep), .tcp_ip_rx_last(e_last),
    .tcp_ip_rx_err(e_err), .tcp_ip_rx_valid(e_valid), .tcp_ip_rx_ready(1'b1),
    .rx_src_mac(e_src), .rx_drop(e_drop)
`ifdef ETH_RX_STATS_EN
    , .stat_good(sg1), .stat_drop(sd1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  function automatic bq_t mk_frame(input logic [47:0] dst, input logic [47:0] src,
                                   input logic [15:0] typ, input int npay);
    bq_t q;
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) q.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(src[8*i +: 8]);
    q.push_back(typ[15:8]);
    q.push_back(typ[7:0]);
    for (int i = 0; i < npay; i++) q.push_back(8'(i + 1));
    return q;
  endfunction

  // Reference model of the payload packer for a given payload limit.
  task automatic expect_pay(input int npay, input int max, input bit to8);
    int   fw = (npay < max) ? npay : max;
    bit   trunc = npay > max;
    exp_t w, pend;
    pend = '0;
    for (int i = 0; i < fw; i += 4) begin
      int k = (fw - i < 4) ? fw - i : 4;
      w = '0;
      for (int j = 0; j < k; j++) w.data[31 - 8*j -: 8] = 8'(i + j + 1);
      w.keep = keep_mask(3'(k));
      if (k == 4 || !trunc) begin
        w.last = !trunc && (i + k == fw);
        if (to8) exp8_q.push_back(w); else exp_q.push_back(w);
      end else pend = w;
    end
    if (trunc) begin
      if (fw % 4 == 0) pend = '0;
      pend.last = 1'b1;
      pend.err  = 1'b1;
      if (to8) exp8_q.push_back(pend); else exp_q.push_back(pend);
    end
  endtask

  task automatic expect_both(input int npay);
    expect_pay(npay, 1500, 1'b0);
    expect_pay(npay, 8, 1'b1);
  endtask

  // Drives beats at negedge; returns after max_beats beats (or the frame) are accepted.
  task automatic send_frame(input bq_t fb, input int max_beats);
    int nb = (fb.size() + 5) / 6;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      logic [47:0] d = '0;
      int t = 0;
      for (int j = 0; j < 6; j++)
        if (b*6 + j < fb.size()) d[47 - 8*j -: 8] = fb[b*6 + j];
      mac_rx_data  = d;
      mac_rx_valid = 1'b1;
      mac_rx_last  = (b == nb - 1);
      mac_rx_bytes = (b == nb - 1) ? 3'(fb.size() - 6*b) : 3'd6;
      while (!mac_rx_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        chk("beat_timeout", 64'(t), 64'd0);
        mac_rx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    mac_rx_valid = 1'b0;
    mac_rx_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    chk("rst_mac_ready", 64'(mac_rx_ready), 64'd0);
    chk("rst_valid", 64'(d_valid), 64'd0);
    chk("rst_word", {26'd0, d_data, d_keep, d_last, d_err}, 64'd0);
    chk("rst_src_mac", 64'(d_src), 64'd0);
    chk("rst_drop", 64'(d_drop), 64'd0);
  endtask

  // Monitors sample 1 time unit after the negedge, when stimulus is settled.
  always @(negedge clk) begin
    exp_t w;
    #1;
    if (!rst && d_valid && tcp_rdy) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      else begin
        w = exp_q.pop_front();
        chk("word", {26'd0, d_data & kmask(d_keep), d_keep, d_last, d_err},
            {26'd0, w.data & kmask(w.keep), w.keep, w.last, w.err});
      end
    end
    if (!rst && d_valid && !tcp_rdy) begin
      if (held) chk("stall_stable", 64'({d_data, d_keep, d_last, d_err}), 64'(prev_w));
      prev_w = {d_data, d_keep, d_last, d_err};
      held   = 1;
    end else held = 0;
    if (!rst && d_drop) drop_cnt++;
  end

  always @(negedge clk) begin
    exp_t w;
    #1;
    if (!rst && e_valid) begin
      if (exp8_q.size() == 0) chk("sb8_underflow", 64'(exp8_q.size()), 64'd1);
      else begin
        w = exp8_q.pop_front();
        chk("word8", {26'd0, e_data & kmask(e_keep), e_keep, e_last, e_err},
            {26'd0, w.data & kmask(w.keep), w.keep, w.last, w.err});
      end
    end
  end

  initial begin
    bq_t f;
    int  d0, h0, t;
    idle(3);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(mac_rx_ready), 64'd1);

    // nominal 8-byte payload
    expect_both(8);
    send_frame(mk_frame(MY_MAC, 48'h000A35000002, 16'h0800, 8), 99);
    idle(15);
    chk("src_mac_nom", 64'(d_src), 64'h000A35000002);
    chk("sb_drained_nom", 64'(exp_q.size()), 64'd0);

    // 5-byte payload: partial last word
    expect_both(5);
    send_frame(mk_frame(MY_MAC, 48'h000A35000002, 16'h0800, 5), 99);
    idle(15);
    chk("sb_drained_5", 64'(exp_q.size()), 64'd0);

    // wrong destination, then a good frame
    d0 = drop_cnt; h0 = hs_cnt;
    send_frame(mk_frame(48'h000A35000009, 48'h000A35000002, 16'h0800, 8), 99);
    idle(15);
    chk("dst_drop_cnt", 64'(drop_cnt - d0), 64'd1);
    chk("dst_no_output", 64'(hs_cnt - h0), 64'd0);
    expect_both(4);
    send_frame(mk_frame(MY_MAC, 48'h000A35000003, 16'h0800, 4), 99);
    idle(15);
    chk("src_mac_after_drop", 64'(d_src), 64'h000A35000003);
    chk("sb_drained_dst", 64'(exp_q.size()), 64'd0);

    // wrong EtherType, then a 10-byte runt
    d0 = drop_cnt; h0 = hs_cnt;
    send_frame(mk_frame(MY_MAC, 48'h000A35000002, 16'h86DD, 8), 99);
    idle(15);
    chk("type_drop_cnt", 64'(drop_cnt - d0), 64'd1);
    f = mk_frame(MY_MAC, 48'h000A35000002, 16'h0800, 8);
    f = f[0:9];
    send_frame(f, 99);
    idle(15);
    chk("runt_drop_cnt", 64'(drop_cnt - d0), 64'd2);
    chk("type_runt_no_output", 64'(hs_cnt - h0), 64'd0);

    // back-pressure for 20 cycles during a 12-byte payload
    expect_both(12);
    tcp_rdy = 1'b0;
    fork
      send_frame(mk_frame(MY_MAC, 48'h000A35000004, 16'h0800, 12), 99);
      begin
        t = 0;
        while (!d_valid && t < 500) begin
          @(negedge clk);
          t++;
        end
        chk("stall_first_word_seen", 64'(d_valid), 64'd1);
        idle(20);
        chk("stall_mac_ready_low", 64'(mac_rx_ready), 64'd0);
        tcp_rdy = 1'b1;
      end
    join
    idle(15);
    chk("sb_drained_stall", 64'(exp_q.size()), 64'd0);

    // 10-byte payload: limit 8 on a word boundary in dut8
    expect_both(10);
    send_frame(mk_frame(MY_MAC, 48'h000A35000005, 16'h0800, 10), 99);
    idle(15);
    chk("sb_drained_trunc", 64'(exp_q.size()), 64'd0);
    chk("sb8_drained_trunc", 64'(exp8_q.size()), 64'd0);

    // reset while two payload bytes are packed
    send_frame(mk_frame(MY_MAC, 48'h000A35000006, 16'h0800, 10), 4);
    idle(7);
    chk("src_mac_pre_rst", 64'(d_src), 64'h000A35000006);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", 64'(mac_rx_ready), 64'd1);

    // recovery
    expect_both(8);
    send_frame(mk_frame(MY_MAC, 48'h000A35000002, 16'h0800, 8), 99);
    idle(15);
    chk("sb_drained_end", 64'(exp_q.size()), 64'd0);
    chk("sb8_drained_end", 64'(exp8_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/eth_rx_deframer.md
# eth_rx_deframer

Receive-side Ethernet deframer between the MAC receive word stream and the TCP/IP stack. It accepts 48-bit MAC beats, six bytes per beat, and serialises them to bytes. It then checks preamble/SFD, destination MAC and EtherType, captures the source MAC, and packs the IPv4 payload into 32-bit words with last, keep and error qualifiers. It is the counterpart of the transmit framer, which emits preamble, SFD, dst, src, EtherType and payload in the same byte order.

## Interface
- MAC_ADDR_LOCAL, 48'h000A35000001, station address accepted as destination
- MAX_PAYLOAD_BYTES, 1500, payload bytes forwarded per frame before truncation
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mac_rx_data  in  48  beat; byte 0 = [47:40], first on wire
- mac_rx_valid  in  1  beat valid
- mac_rx_last  in  1  beat is final beat of frame
- mac_rx_bytes  in  3  valid bytes in last beat, 1..6; ignored unless mac_rx_last
- mac_rx_ready  out  1  beat accepted when valid && ready
- tcp_ip_rx_data  out  32  payload word, first byte in [31:24]
- tcp_ip_rx_keep  out  4  byte enables, MSB-first contiguous (4'b1000..4'b1111)
- tcp_ip_rx_last  out  1  final word of frame
- tcp_ip_rx_err  out  1  valid on last word; frame truncated (oversize)
- tcp_ip_rx_valid  out  1  word valid
- tcp_ip_rx_ready  in  1  word accepted when valid && ready
- rx_src_mac  out  48  source MAC of current/last accepted frame
- rx_drop  out  1  one-cycle pulse per discarded frame

## Operation
- Unpacker: a 48-bit hold register plus a byte index 0..5; presents one byte per cycle to the parser; the frame-final byte is tagged at index mac_rx_bytes-1 of the last beat.
- FSM states: HUNT, PRE, DST, SRC, TYPE, PAY, DROP.
- HUNT: 0x55 goes to PRE. Any other byte goes to DROP.
- PRE: 0x55 increments the preamble count (max 7). 0xD5 goes to DST. Any other byte, or an 8th 0x55, goes to DROP.
- DST: 6 bytes are compared with MAC_ADDR_LOCAL. On mismatch after byte 6, go to DROP.
- SRC: 6 bytes are shifted into a shadow register, which is copied to rx_src_mac on entry to PAY.
- TYPE: 2 bytes. 16'h0800 goes to PAY; anything else goes to DROP.
- PAY: bytes are packed MSB-first; a word is emitted on its 4th byte or on the frame-final byte.
  - Keep marks the packed bytes; last is set on the frame-final byte.
  - After MAX_PAYLOAD_BYTES, further bytes are discarded. The last word is emitted when the frame-final byte arrives, with err=1.
  - If the limit falls exactly on a word boundary, a word with keep=4'b0000, last=1, err=1 is emitted at frame end.
- DROP: bytes are discarded until the frame-final byte. rx_drop pulses on that byte; the FSM then returns to HUNT.
- Frame-final byte in any state before PAY (runt): pulse rx_drop, go to HUNT, emit no output.
- Frame-final byte in PAY: emit the last word, go to HUNT.
- Payload byte counter is 11 bits and saturates at MAX_PAYLOAD_BYTES; no wrap.

## Timing
- Reset values: mac_rx_ready=0; tcp_ip_rx_valid/last/err=0; keep=0; data=0; rx_src_mac=0; rx_drop=0; FSM=HUNT; hold register empty.
- mac_rx_ready=1 in the first cycle after rst deasserts; it is combinational on hold-register-empty.
- Beat handshake in cycle N: byte 0 is consumed in N+1 and byte k in N+1+k, absent stalls. Ready reasserts in the cycle after the last byte is consumed, giving 7 cycles per full beat.
- Output word is registered: valid asserts in the cycle after the completing byte. It holds data/keep/last/err stable until ready.
- Stall: a completing byte is not consumed while valid && !ready. Non-completing bytes continue to pack.
- Same-cycle drain and complete is allowed: the new word loads as the old word is accepted (no bubble).
- rst mid-frame: state returns to reset values next cycle. A partial output word is discarded; no rx_drop pulse.

## Configuration
- ETH_RX_STATS_EN defined: adds outputs stat_good [15:0] and stat_drop [15:0].
  - stat_good increments on each last-word handshake; stat_drop increments on each rx_drop pulse.
  - Both saturate at 16'hFFFF and reset to 0.
- ETH_RX_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package eth_pkg holds:
  - ETH_PREAMBLE_BYTE=8'h55, ETH_SFD=8'hD5, ETH_TYPE_IPV4=16'h0800
  - ETH_HDR_BYTES=14
  - FSM state enum, shared with the transmit framer for consistent encoding
- Sub-module eth_rx_unpack: 48-to-8 gearbox with hold register, byte index, final-byte tag and stall input.

## Test plan
- Nominal frame: 7×0x55, 0xD5, dst 000A35000001, src 000A35000002, type 0800, 8-byte payload 01..08.
  - Expect words 0x01020304, then 0x05060708 with keep=F, last=1, err=0.
  - rx_src_mac=000A35000002.
- Payload of 5 bytes: last word data 0x05xxxxxx with keep=4'b1000, last=1.
- Dst 000A35000009: no output; rx_drop pulses once on the frame-final byte; the next good frame passes.
- Type 0x86DD, plus a runt ending after 10 bytes: each gives one rx_drop pulse and no tcp_ip_rx_valid.
- Hold tcp_ip_rx_ready=0 for 20 cycles during a 12-byte payload:
  - mac_rx_ready stays low and no word is lost or reordered;
  - data is stable while valid.
- MAX_PAYLOAD_BYTES=8 with a 10-byte payload: words 1–2 forwarded, then keep=0, last=1, err=1. Assert rst mid-payload and check reset values the next cycle.
